// File: rtl/seq_pkg.sv
// Shared types and defaults for the 1011 stimulus generator.
// Imported by the generator top and its window sub-block.
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    FIN
  } state_e;

  localparam int SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1011;
endpackage

// File: rtl/pattern_window.sv
// Sliding window over emitted stream bits plus pattern compare.
// Match includes the bit presented this cycle (Mealy timing).
module pattern_window
  import seq_pkg::*;
#(
  parameter int                PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = SEQ_PATTERN
) (
  input  logic clk,
  input  logic areset_n,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  // Oldest bit falls out at the shift, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (clr) begin
      win_d = '0;
    end else if (shift_en) begin
      win_d = (win_q << 1) | (PAT_W-1)'(bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign match = shift_en & ({win_q, bit_in} == PATTERN);

endmodule

// File: rtl/seq_gen_1011.sv
// Serial burst generator for the 1011 detector, with expected
// match flag and saturating match count for direct comparison.
module seq_gen_1011
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             exp_match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             win_clr;
  logic             cnt_clr;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    win_clr = 1'b0;
    cnt_clr = 1'b0;
    ready   = 1'b0;
    x       = 1'b0;
    x_valid = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE, FIN: begin
        ready   = 1'b1;
        done    = (state_q == FIN);
        state_d = IDLE;
        if (start) begin
          cnt_clr = 1'b1;
          if (rep != '0) begin
            rem_d   = rep;
            gap_d   = gap;
            idx_d   = IDX_LAST;
            win_clr = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = FIN;
          end
        end
      end
      SHIFT: begin
        x       = PATTERN[idx_q];
        x_valid = 1'b1;
        if (idx_q == '0) begin
          rem_d = rem_q - CNT_W'(1);
          idx_d = IDX_LAST;
          if (rem_q == CNT_W'(1)) begin
            state_d = FIN;
          end else if (gap_q != '0) begin
            gcnt_d  = gap_q;
            state_d = GAP;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      GAP: begin
        x_valid = 1'b1;
        gcnt_d  = gcnt_q - GAP_W'(1);
        if (gcnt_q == GAP_W'(1)) begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (exp_match && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  pattern_window #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_win (
    .clk      (clk),
    .areset_n (areset_n),
    .clr      (win_clr),
    .shift_en (x_valid),
    .bit_in   (x),
    .match    (exp_match)
  );

  assign match_cnt = cnt_q;

endmodule

// File: doc/seq_gen_1011.md
# seq_gen_1011

- Serial stimulus transmitter for the 1011 overlapping sequence detector.
- Serializes a fixed PAT_W-bit pattern, MSB first, for a programmable number of repetitions with a programmable zero-bit gap between them.
- Also produces a Mealy-aligned expected-match flag and a match count, so the bench compares these directly against the detector's op.
- Sits upstream of the detector: x drives the detector's x; both share clk.

## Interface
- PAT_W, 4, pattern length in bits
- PATTERN, 4'b1011, pattern emitted MSB first
- CNT_W, 8, width of rep and match_cnt
- GAP_W, 4, width of gap
- clk  in  1  rising-edge clock, single clock domain
- areset_n  in  1  reset, synchronous and active-low
- start  in  1  request to begin a burst; honoured only when ready=1
- rep  in  CNT_W  pattern repetitions; sampled with start
- gap  in  GAP_W  zero bits inserted between repetitions; sampled with start
- ready  out  1  idle, start accepted
- x  out  1  serial bit
- x_valid  out  1  x carries a stream bit this cycle
- done  out  1  one-cycle pulse at burst end
- exp_match  out  1  the last PAT_W valid bits, including the current x, equal PATTERN
- match_cnt  out  CNT_W  exp_match count since last accepted start; saturates at all-ones

## Operation
- FSM states:
  - IDLE: ready=1, x=0, x_valid=0.
    - start=1 and rep≠0: latch rep/gap, clear window and match_cnt, go to SHIFT with bit index PAT_W-1.
    - start=1 and rep=0: clear match_cnt, go to FIN.
  - SHIFT: x=PATTERN[idx], x_valid=1. At idx=0, decrement the remaining-repetition count.
    - Remaining=0: go to FIN.
    - Otherwise, gap≠0: go to GAP. gap=0: reload idx and stay in SHIFT.
  - GAP: x=0, x_valid=1 for exactly gap cycles, then SHIFT with idx reloaded.
  - FIN: done=1, ready=1, x_valid=0; next state IDLE. A start in FIN is accepted exactly as in IDLE.
- Window: PAT_W-bit shift register, updated only on x_valid cycles.
  - exp_match = x_valid & ({window[PAT_W-2:0], x} == PATTERN), combinational.
  - Overlap is allowed.
- match_cnt increments on every exp_match cycle and holds at 2^CNT_W-1.
- start while not ready is ignored; rep and gap are not re-sampled mid-burst.
- areset_n=0 at any clock edge, including mid-burst:
  - Next state is IDLE.
  - window and match_cnt are cleared.
  - Outputs take their reset values: ready=1 (IDLE), x=0, x_valid=0, done=0, exp_match=0, match_cnt=0.

## Timing
- start sampled at edge k → first pattern bit valid in cycle k+1.
- Burst length in cycles: rep*PAT_W + (rep-1)*gap.
- done pulses in the cycle after the last valid bit; that cycle is also the first in which ready=1.
- rep=0: done in cycle k+1, no valid bits.
- exp_match is asserted in the same cycle as the final pattern bit, matching the detector's Mealy op timing.
- Back-to-back bursts: a start accepted in the FIN cycle produces its first bit two cycles after the previous burst's last bit.

## Structure
- Package seq_pkg holds:
  - FSM state enum (IDLE, SHIFT, GAP, FIN)
  - default PATTERN and PAT_W constants
- Sub-module pattern_window: window register plus comparator. Ports: clk, areset_n, clr, shift_en, bit_in, match.

## Test plan
- Reset mid-burst: areset_n low during SHIFT of a rep=5 burst → next cycle ready=1, x_valid=0, match_cnt=0; no done pulse.
- rep=2, gap=0 → x=10111011 over 8 cycles; exp_match in cycles 4 and 8; match_cnt=2; done in cycle 9.
- rep=3, gap=2 → 1011 00 1011 00 1011 (16 bits); 3 matches; done in cycle 17.
- rep=0 with start → done in the next cycle, x_valid never high, match_cnt=0.
- start pulsed during a burst and in the FIN cycle → the mid-burst start is ignored; the FIN start begins a new burst and match_cnt restarts at 0.
- CNT_W=2, rep=3 gap=0 → match_cnt saturates at 3; a further burst with rep=3 also ends at 3.
